// File: rtl/bridge_pkg.sv
// Shared definitions for the IO bridge device side: default word addresses,
// CTRL register bit layout, timer mode encodings, timer FSM states and a
// byte-enable merge helper used by every writable register.
package bridge_pkg;

  localparam logic [11:0] TIMER_BASE_DEF = 12'hFC0;
  localparam logic [11:0] LED_ADDR_DEF   = 12'hFC4;
  localparam logic [11:0] SW_ADDR_DEF    = 12'hFC5;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } timer_state_t;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/io_bridge_timer_timer_core.sv
// Programmable countdown timer: CTRL/PRESET/COUNT registers, the timer FSM
// and the interrupt-pending flag.
// Ports:
//   clk, rst             clock, async active-high reset
//   we_ctrl, we_preset   decoded single-register write strobes
//   be, wd               byte enables and lane-aligned write data
//   ctrl, preset, count  register values for readback (ctrl[31:4] = 0)
//   irq                  irq_pending gated by CTRL.IM
module timer_core
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_ctrl,
  input  logic        we_preset,
  input  logic [3:0]  be,
  input  logic [31:0] wd,
  output logic [31:0] ctrl,
  output logic [31:0] preset,
  output logic [31:0] count,
  output logic        irq
);

  logic [3:0]   ctrl_q;
  logic [31:0]  preset_q;
  logic [31:0]  count_q;
  logic [31:0]  count_nxt;
  logic         irq_pending;
  logic         en;
  logic         auto_mode;
  timer_state_t state;
  timer_state_t state_nxt;

  assign en        = ctrl_q[CTRL_EN];
  // MODE 1x behaves as one-shot, so only the exact auto encoding reloads.
  assign auto_mode = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);

  always_comb begin
    state_nxt = state;
    count_nxt = count_q;
    case (state)
      IDLE: if (en) state_nxt = LOAD;
      LOAD: begin
        if (!en) begin
          state_nxt = IDLE;
        end else begin
          count_nxt = preset_q;
          state_nxt = CNT;
        end
      end
      CNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (count_q > 32'd1) begin
          count_nxt = count_q - 32'd1;
        end else begin
          count_nxt = 32'd0;
          state_nxt = INT;
        end
      end
      INT: begin
        if (!en || !auto_mode) state_nxt = IDLE;
        else                   state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ctrl_q      <= 4'd0;
      preset_q    <= 32'd0;
      count_q     <= 32'd0;
      irq_pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      count_q <= count_nxt;

      if (we_preset) preset_q <= be_merge(preset_q, wd, be);

      // A CPU write to CTRL overrides the one-shot EN clear in INT.
      if (we_ctrl) begin
        if (be[0]) ctrl_q <= wd[3:0];
      end else if (state == INT && !auto_mode) begin
        ctrl_q[CTRL_EN] <= 1'b0;
      end

      // Any CTRL write acknowledges; auto-reload self-clears after one cycle.
      if (we_ctrl)            irq_pending <= 1'b0;
      else if (state == INT)  irq_pending <= 1'b1;
      else if (auto_mode)     irq_pending <= 1'b0;
    end
  end

  assign ctrl   = {28'd0, ctrl_q};
  assign preset = preset_q;
  assign count  = count_q;
  assign irq    = irq_pending & ctrl_q[CTRL_IM];

endmodule

// File: rtl/io_bridge_timer.sv
// Device-side responder of the processor-to-peripheral bridge. Decodes the
// IO-region word address onto the timer, a LED output register and a switch
// input register, and returns registered read data one cycle after PrAddr.
// Ports:
//   clk, rst   clock, async active-high reset
//   IOWrite    write strobe for the IO region
//   PrAddr     word address (byte address bits 13:2)
//   PrWD/PrBE  lane-shifted write data and byte enables
//   PrRD       registered read data
//   IRQ        timer interrupt request (level)
//   sw_in      external switch levels
//   led_out    LED register contents
module io_bridge_timer
  import bridge_pkg::*;
#(
  parameter logic [11:0] TIMER_BASE = TIMER_BASE_DEF,
  parameter logic [11:0] LED_ADDR   = LED_ADDR_DEF,
  parameter logic [11:0] SW_ADDR    = SW_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IOWrite,
  input  logic [11:0] PrAddr,
  input  logic [31:0] PrWD,
  input  logic [3:0]  PrBE,
  output logic [31:0] PrRD,
  output logic        IRQ,
  input  logic [31:0] sw_in,
  output logic [31:0] led_out
);

  localparam logic [11:0] PRESET_ADDR = TIMER_BASE + 12'd1;
  localparam logic [11:0] COUNT_ADDR  = TIMER_BASE + 12'd2;

  logic        we_ctrl;
  logic        we_preset;
  logic        we_led;
  logic [31:0] ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [31:0] led_q;
  logic [31:0] sw_q;
  logic [31:0] rd_nxt;

  // COUNT and the switch register have no write strobe.
  assign we_ctrl   = IOWrite && (PrAddr == TIMER_BASE);
  assign we_preset = IOWrite && (PrAddr == PRESET_ADDR);
  assign we_led    = IOWrite && (PrAddr == LED_ADDR);

  timer_core u_timer (
    .clk       (clk),
    .rst       (rst),
    .we_ctrl   (we_ctrl),
    .we_preset (we_preset),
    .be        (PrBE),
    .wd        (PrWD),
    .ctrl      (ctrl),
    .preset    (preset),
    .count     (count),
    .irq       (IRQ)
  );

  // Mux sees pre-edge register values, so a same-cycle write reads old data.
  always_comb begin
    rd_nxt = 32'd0;
    if      (PrAddr == TIMER_BASE)  rd_nxt = ctrl;
    else if (PrAddr == PRESET_ADDR) rd_nxt = preset;
    else if (PrAddr == COUNT_ADDR)  rd_nxt = count;
    else if (PrAddr == LED_ADDR)    rd_nxt = led_q;
    else if (PrAddr == SW_ADDR)     rd_nxt = sw_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= 32'd0;
      sw_q  <= 32'd0;
      PrRD  <= 32'd0;
    end else begin
      if (we_led) led_q <= be_merge(led_q, PrWD, PrBE);
      sw_q <= sw_in;
      PrRD <= rd_nxt;
    end
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_io_bridge_timer.sv
module tb_io_bridge_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        IOWrite;
  logic [11:0] PrAddr;
  logic [31:0] PrWD;
  logic [3:0]  PrBE;
  logic [31:0] PrRD;
  logic        IRQ;
  logic [31:0] sw_in;
  logic [31:0] led_out;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [11:0] A_CTRL   = 12'hFC0;
  localparam logic [11:0] A_PRESET = 12'hFC1;
  localparam logic [11:0] A_COUNT  = 12'hFC2;
  localparam logic [11:0] A_UNMAP  = 12'hFC3;
  localparam logic [11:0] A_LED    = 12'hFC4;
  localparam logic [11:0] A_SW     = 12'hFC5;

  io_bridge_timer dut (
    .clk     (clk),
    .rst     (rst),
    .IOWrite (IOWrite),
    .PrAddr  (PrAddr),
    .PrWD    (PrWD),
    .PrBE    (PrBE),
    .PrRD    (PrRD),
    .IRQ     (IRQ),
    .sw_in   (sw_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
    IOWrite = 1'b1;
    PrAddr  = a;
    PrWD    = d;
    PrBE    = b;
    tick();
    IOWrite = 1'b0;
    PrBE    = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst     = 1'b1;
    IOWrite = 1'b0;
    PrAddr  = 12'h000;
    PrWD    = 32'd0;
    PrBE    = 4'b0000;
    sw_in   = 32'h5A5A1234;

    // Reset state
    #2;
    chk("rst_prrd", PrRD, 32'd0);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    chk("rst_led", led_out, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Reset mid-count
    wr(A_LED, 32'h0000_00FF, 4'hF);
    wr(A_PRESET, 32'd5, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    PrAddr = A_COUNT;
    tick(); tick(); tick();
    chk("midcnt_count", PrRD, 32'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("midcnt_rst_prrd", PrRD, 32'd0);
    chk("midcnt_rst_irq", {31'd0, IRQ}, 32'd0);
    chk("midcnt_rst_led", led_out, 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("midcnt_count_after", PrRD, 32'd0);
    PrAddr = A_CTRL;
    tick();
    chk("midcnt_ctrl_after", PrRD, 32'd0);

    // Read latency / decode
    wr(A_PRESET, 32'h1234, 4'hF);
    PrAddr = A_PRESET;
    tick();
    chk("rd_preset", PrRD, 32'h1234);
    wr(A_PRESET, 32'hFFFF_FFFF, 4'b0001);
    tick();
    chk("rd_preset_be", PrRD, 32'h12FF);
    PrAddr = A_UNMAP;
    tick();
    chk("rd_unmapped", PrRD, 32'd0);
    wr(A_COUNT, 32'hDEAD_BEEF, 4'hF);
    tick();
    chk("count_wr_ignored", PrRD, 32'd0);

    // One-shot: PRESET=3
    wr(A_PRESET, 32'd3, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    PrAddr = A_COUNT;
    tick(); tick();
    tick(); chk("os_count3", PrRD, 32'd3);
    tick(); chk("os_count2", PrRD, 32'd2);
    tick(); chk("os_count1", PrRD, 32'd1);
    chk("os_irq_in_int", {31'd0, IRQ}, 32'd0);
    tick(); chk("os_count0", PrRD, 32'd0);
    chk("os_irq_rise", {31'd0, IRQ}, 32'd1);
    PrAddr = A_CTRL;
    tick();
    chk("os_ctrl_en_clr", PrRD, 32'h8);
    chk("os_irq_hold1", {31'd0, IRQ}, 32'd1);
    tick(); tick();
    chk("os_irq_hold2", {31'd0, IRQ}, 32'd1);
    wr(A_CTRL, 32'h8, 4'hF);
    chk("os_irq_ack", {31'd0, IRQ}, 32'd0);

    // Auto-reload PRESET=2: LOAD, CNT, CNT, INT repeats every 4 cycles;
    // first pending cycle is 5 edges after the CTRL write.
    wr(A_PRESET, 32'd2, 4'hF);
    wr(A_CTRL, 32'hB, 4'hF);
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk($sformatf("auto_irq_%0d", k), {31'd0, IRQ},
          ((k == 5) || (k == 9) || (k == 13) || (k == 17)) ? 32'd1 : 32'd0);
    end
    wr(A_CTRL, 32'h3, 4'hF);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("auto_masked_%0d", k), {31'd0, IRQ}, 32'd0);
    end
    wr(A_CTRL, 32'h0, 4'hF);

    // Byte-enable LED writes and switch register
    wr(A_LED, 32'hFFFF_FFFF, 4'hF);
    chk("led_same_cycle_old", PrRD, 32'd0);
    chk("led_full", led_out, 32'hFFFF_FFFF);
    wr(A_LED, 32'h00AB_0000, 4'b0100);
    chk("led_byte2", led_out, 32'hFFAB_FFFF);
    tick();
    chk("led_readback", PrRD, 32'hFFAB_FFFF);
    wr(A_SW, 32'h0000_0000, 4'hF);
    tick();
    chk("sw_wr_ignored", PrRD, 32'h5A5A_1234);
    sw_in = 32'hC0FF_EE00;
    tick();
    chk("sw_latency_old", PrRD, 32'h5A5A_1234);
    tick();
    chk("sw_latency_new", PrRD, 32'hC0FF_EE00);

    // Collision: CTRL write during one-shot INT
    wr(A_PRESET, 32'd1, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    tick(); tick(); tick();
    wr(A_CTRL, 32'h9, 4'hF);
    chk("col_irq_cleared", {31'd0, IRQ}, 32'd0);
    PrAddr = A_CTRL;
    tick();
    chk("col_en_kept", PrRD, 32'h9);
    PrAddr = A_COUNT;
    tick();
    tick();
    chk("col_reload", PrRD, 32'd1);
    tick();
    chk("col_second_irq", {31'd0, IRQ}, 32'd1);
    wr(A_CTRL, 32'h0, 4'hF);
    chk("col_final_ack", {31'd0, IRQ}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
